// File: rtl/hilo_div_seq.sv
// hilo_div_seq: HI/LO register pair plus the sequencer that drives the iterative divide engine.
// Handles DIV/DIVU/MTHI/MTLO/MFHI/MFLO, stalls decode while a divide is in flight, aborts on timeout.
module hilo_div_seq #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_done,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic        busy,
    output logic        div_zero,
    output logic        div_timeout
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_COMMIT} state_t;

    localparam logic [2:0] OP_DIV = 3'b000, OP_MTHI = 3'b010, OP_MTLO = 3'b011,
                           OP_MFHI = 3'b100, OP_MFLO = 3'b101;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       hi, lo;
    logic              take, is_div, launch, expire;

    assign take   = op_valid && op_ready;
    assign is_div = take && op_code[2:1] == OP_DIV[2:1];
    assign launch = is_div && op_b != '0;
    assign expire = state == S_WAIT && !div_done && cnt == CNT_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // done has priority over the timeout when both land on the same edge
    always_comb begin
        state_n = state == S_IDLE   ? (launch ? S_LAUNCH : S_IDLE) :
                  state == S_LAUNCH ? S_WAIT :
                  state == S_WAIT   ? (div_done ? S_COMMIT : (expire ? S_IDLE : S_WAIT)) :
                                      S_IDLE;
    end

    always_comb begin
        op_ready  = state == S_IDLE;
        busy      = state != S_IDLE;
        div_start = state == S_LAUNCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi           <= '0;
            lo           <= '0;
            cnt          <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            div_signed   <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_zero     <= 1'b0;
            div_timeout  <= 1'b0;
        end else begin
            rd_valid    <= take && (op_code == OP_MFHI || op_code == OP_MFLO);
            div_zero    <= is_div && op_b == '0;
            div_timeout <= expire;
            cnt         <= state == S_WAIT ? cnt + 1'b1 : '0;
            if (take && op_code == OP_MFHI)
                rd_data <= hi;
            if (take && op_code == OP_MFLO)
                rd_data <= lo;
            if (take && op_code == OP_MTHI)
                hi <= op_a;
            if (take && op_code == OP_MTLO)
                lo <= op_a;
            // operands only change in IDLE, so they stay put until COMMIT
            if (launch) begin
                div_signed   <= ~op_code[0];
                div_dividend <= op_a;
                div_divisor  <= op_b;
            end
            if (state == S_WAIT && div_done) begin
                lo <= div_quotient;
                hi <= div_remainder;
            end
        end
    end
endmodule

// File: tb/tb_hilo_div_seq.sv
// tb_hilo_div_seq: directed vectors against hilo_div_seq with a behavioural divide engine.
// Stimulus pushes expected events into a queue; a monitor pops them as the DUT produces them.
module tb_hilo_div_seq;
    localparam logic [2:0] DIV = 3'b000, DIVU = 3'b001, MTHI = 3'b010, MTLO = 3'b011,
                           MFHI = 3'b100, MFLO = 3'b101;
    localparam int ENG_LAT = 33;
    localparam int K_RD = 0, K_ZERO = 1, K_TO = 2, K_START = 3;

    logic        clk = 0, rst = 1;
    logic        op_valid, op_ready, rd_valid, div_start, div_signed, div_done, busy, div_zero, div_timeout;
    logic [2:0]  op_code;
    logic [31:0] op_a, op_b, rd_data, div_dividend, div_divisor, div_quotient, div_remainder;

    typedef struct {int kind; logic [31:0] d; logic [31:0] b; logic s;} exp_t;
    exp_t sb[$];
    int   vectors = 0, miscompares = 0;
    bit   eng_en = 1;

    always #5 clk = ~clk;

    hilo_div_seq dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .rd_data(rd_data), .rd_valid(rd_valid), .div_start(div_start),
        .div_signed(div_signed), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .busy(busy), .div_zero(div_zero), .div_timeout(div_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic observe(input int kind, input string name);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: unexpected event, got kind %0d, expected none", name, kind);
            return;
        end
        e = sb.pop_front();
        chk({name, "_kind"}, kind, e.kind);
        if (kind == e.kind && kind == K_RD)
            chk({name, "_data"}, rd_data, e.d);
        if (kind == e.kind && kind == K_START) begin
            chk({name, "_dividend"}, div_dividend, e.d);
            chk({name, "_divisor"}, div_divisor, e.b);
            chk({name, "_signed"}, {31'b0, div_signed}, {31'b0, e.s});
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rd_valid === 1'b1) observe(K_RD, "rd");
        if (div_zero === 1'b1) observe(K_ZERO, "div_zero");
        if (div_timeout === 1'b1) observe(K_TO, "div_timeout");
        if (div_start === 1'b1) observe(K_START, "div_start");
    end

    // behavioural divide engine: done pulses ENG_LAT cycles after the launch is seen
    initial begin
        logic [31:0] q, r;
        div_done = 0;
        div_quotient = 0;
        div_remainder = 0;
        forever begin
            @(negedge clk);
            if (div_start === 1'b1 && eng_en) begin
                q = div_signed ? 32'($signed(div_dividend) / $signed(div_divisor)) : div_dividend / div_divisor;
                r = div_signed ? 32'($signed(div_dividend) % $signed(div_divisor)) : div_dividend % div_divisor;
                repeat (ENG_LAT) @(negedge clk);
                div_done = 1;
                div_quotient = q;
                div_remainder = r;
                @(negedge clk);
                div_done = 0;
                div_quotient = 0;
                div_remainder = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (op_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (op_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_ready: got op_ready %b, expected 1 within 200 cycles", op_ready);
            return;
        end
        op_valid = 1;
        op_code = c;
        op_a = a;
        op_b = b;
        @(negedge clk);
        op_valid = 0;
        op_a = 0;
        op_b = 0;
    endtask

    task automatic rd(input logic [2:0] c, input logic [31:0] exp);
        sb.push_back('{K_RD, exp, 32'h0, 1'b0});
        issue(c, 32'h0, 32'h0);
    endtask

    task automatic busy_len(input string name, input int exp);
        int n = 0;
        while (op_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, exp);
    endtask

    task automatic divide(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        sb.push_back('{K_START, a, b, c == DIV});
        issue(c, a, b);
        chk("launch_op_ready", {31'b0, op_ready}, 32'h0);
        busy_len("div_busy_cycles", ENG_LAT + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        op_valid = 0;
        op_code = 0;
        op_a = 0;
        op_b = 0;
        repeat (3) @(negedge clk);
        chk("reset_op_ready", {31'b0, op_ready}, 32'h1);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
        chk("reset_div_start", {31'b0, div_start}, 32'h0);
        rst = 0;
        @(negedge clk);
        rd(MFHI, 32'h0);
        rd(MFLO, 32'h0);
        issue(MTHI, 32'h12345678, 32'h0);
        issue(MTLO, 32'h9ABCDEF0, 32'h0);
        rd(MFHI, 32'h12345678);
        rd(MFLO, 32'h9ABCDEF0);
        divide(DIV, 32'hF0000000, 32'h2);
        rd(MFLO, 32'hF8000000);
        rd(MFHI, 32'h0);
        divide(DIVU, 32'hF0000000, 32'h2);
        rd(MFLO, 32'h78000000);
        rd(MFHI, 32'h0);
        divide(DIVU, 32'd7, 32'd2);
        rd(MFLO, 32'd3);
        rd(MFHI, 32'd1);
        sb.push_back('{K_ZERO, 32'h0, 32'h0, 1'b0});
        issue(DIV, 32'd5, 32'd0);
        chk("zero_no_launch", {31'b0, op_ready}, 32'h1);
        rd(MFHI, 32'd1);
        rd(MFLO, 32'd3);
        eng_en = 0;
        sb.push_back('{K_START, 32'd100, 32'd3, 1'b1});
        sb.push_back('{K_TO, 32'h0, 32'h0, 1'b0});
        issue(DIV, 32'd100, 32'd3);
        busy_len("timeout_busy_cycles", 1 + 40);
        eng_en = 1;
        rd(MFHI, 32'd1);
        rd(MFLO, 32'd3);
        sb.push_back('{K_START, 32'd50, 32'd7, 1'b0});
        issue(DIVU, 32'd50, 32'd7);
        repeat (10) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("async_reset_op_ready", {31'b0, op_ready}, 32'h1);
        chk("async_reset_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 0;
        repeat (40) @(negedge clk);
        chk("late_done_busy", {31'b0, busy}, 32'h0);
        rd(MFHI, 32'h0);
        rd(MFLO, 32'h0);
        repeat (3) @(negedge clk);
        while (sb.size() != 0) begin
            exp_t e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got nothing, expected kind %0d", e.kind);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
